// File: rtl/i8088_bus_pkg.sv
// Shared types and helpers for the 8088 minimum-mode bus slave.
// Address widths, FSM states and the window-match function.
package i8088_bus_pkg;

  localparam int MEM_AW = 20;
  localparam int IO_AW  = 16;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    REQ,
    WAIT,
    HOLD
  } bus_slv_state_t;

  function automatic logic in_window(
    input logic [19:0] addr,
    input logic [19:0] base,
    input int          size_log2
  );
    return (addr >> size_log2) == (base >> size_log2);
  endfunction

endpackage

// File: rtl/i8088_wait_ctr.sv
// Saturating wait-state counter for the bus slave.
// Loading counts the strobe-sample cycle as the first wait cycle.
module i8088_wait_ctr (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] limit,
  output logic       done
);

  logic [3:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= 4'd0;
    end else if (clr) begin
      cnt_q <= (limit != 4'd0) ? 4'd1 : 4'd0;
    end else if (en && cnt_q != limit) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign done = (cnt_q == limit);

endmodule

// File: rtl/i8088_bus_slave.sv
// Peripheral-side slave for the 8088 bus: address decode, wait states,
// and conversion of each selected strobe into one local req/ack transfer.
module i8088_bus_slave
  import i8088_bus_pkg::*;
#(
  parameter int          IO_SPACE    = 0,
  parameter logic [19:0] BASE_ADDR   = 20'hF0000,
  parameter int          SIZE_LOG2   = 12,
  parameter int          WAIT_STATES = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ALE,
  input  logic                 IOM,
  input  logic                 RD,
  input  logic                 WR,
  input  logic [11:0]          A,
  input  logic [7:0]           ad_in,
  output logic [7:0]           ad_out,
  output logic                 ad_oe,
  output logic                 READY,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [SIZE_LOG2-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_ack,
  output logic                 bus_err
);

  localparam int W = (IO_SPACE != 0) ? IO_AW : MEM_AW;
  localparam logic [19:0] WMASK = 20'((1 << W) - 1);

  bus_slv_state_t state_q, state_d;

  logic [SIZE_LOG2-1:0] offs_q;
  logic                 sel_q;
  logic                 stale_q;
  logic                 ack_seen_q;
  logic [7:0]           ad_out_q;
  logic                 ad_oe_q;
  logic                 ready_q;
  logic                 req_q;
  logic                 we_q;
  logic [SIZE_LOG2-1:0] maddr_q;
  logic [7:0]           wdata_q;
  logic                 err_q;

  logic [19:0] bus_addr;
  logic        sel_now;
  logic        go;
  logic        err;
  logic        leave;
  logic        done;

  assign bus_addr = {A, ad_in} & WMASK;
  assign sel_now  = (IOM == (IO_SPACE != 0)) &&
                    in_window(bus_addr, BASE_ADDR & WMASK, SIZE_LOG2);

  // A pending stale ack blocks new requests so acks never cross accesses.
  assign go    = (state_q == ADDR) && !ALE && sel_q &&
                 (RD ^ WR) && !stale_q;
  assign err   = (state_q == ADDR) && !ALE && sel_q && !RD && !WR;
  assign leave = (state_q == WAIT) && !ALE && done &&
                 (ack_seen_q || mem_ack);

  i8088_wait_ctr u_wait (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (go),
    .en    ((state_q == REQ) || (state_q == WAIT)),
    .limit (4'(WAIT_STATES)),
    .done  (done)
  );

  always_comb begin
    state_d = state_q;
    if (ALE) begin
      state_d = ADDR;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        ADDR: begin
          if (err)     state_d = HOLD;
          else if (go) state_d = REQ;
        end
        REQ:  state_d = WAIT;
        WAIT: if (leave) state_d = HOLD;
        HOLD: if (RD && WR) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      offs_q     <= '0;
      sel_q      <= 1'b0;
      stale_q    <= 1'b0;
      ack_seen_q <= 1'b0;
      ad_out_q   <= 8'h00;
      ad_oe_q    <= 1'b0;
      ready_q    <= 1'b1;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      maddr_q    <= '0;
      wdata_q    <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= go;
      if (ALE) begin
        offs_q <= bus_addr[SIZE_LOG2-1:0];
        sel_q  <= sel_now;
      end
      if (go) begin
        we_q       <= ~WR;
        maddr_q    <= offs_q;
        ready_q    <= 1'b0;
        ack_seen_q <= 1'b0;
        if (!WR) wdata_q <= ad_in;
      end
      if (err) err_q <= 1'b1;
      if (state_q == WAIT && mem_ack) begin
        ack_seen_q <= 1'b1;
        if (!we_q) ad_out_q <= mem_rdata;
      end
      if (leave) begin
        ready_q <= 1'b1;
        ad_oe_q <= ~we_q & ~RD;
      end
      if (state_q == HOLD) ad_oe_q <= ad_oe_q & ~RD;
      if (stale_q && mem_ack) stale_q <= 1'b0;
      // Abort: an ack still owed to the dropped access must be swallowed.
      if (ALE) begin
        ready_q <= 1'b1;
        ad_oe_q <= 1'b0;
        if (state_q == REQ ||
            (state_q == WAIT && !ack_seen_q && !mem_ack))
          stale_q <= 1'b1;
      end
    end
  end

  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign READY     = ready_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_i8088_bus_slave.sv
// Directed bench: three slaves share one bus (memory WS=1, memory WS=3,
// IO window 0x0300/16) with an auto-acking local memory model per slave.
module tb_i8088_bus_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ale = 1'b0;
  logic iom = 1'b0;
  logic rd  = 1'b1;
  logic wr  = 1'b1;
  logic [11:0] a = 12'h000;
  logic [7:0] adi = 8'h00;

  logic [7:0] dout[3];
  logic [7:0] wdat[3];
  logic [7:0] rdata[3] = '{8'h00, 8'h00, 8'h00};
  logic oe[3];
  logic ready[3];
  logic req[3];
  logic we[3];
  logic berr[3];
  logic ack[3] = '{1'b0, 1'b0, 1'b0};
  logic [11:0] maddr0, maddr1;
  logic [3:0]  maddr2;

  int dly[3]  = '{1, 1, 1};
  int acnt[3] = '{0, 0, 0};

  int checks = 0;
  int errors = 0;

  int nlow[3], nreq[3], firstlow[3];
  logic [11:0] raddr[3];
  logic [7:0]  rwd[3], oedata[3];
  logic rwe[3], oe_seen[3], oe_last[3], oe_after[3];

  always #5 clk = ~clk;

  i8088_bus_slave u0 (
    .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD(rd), .WR(wr),
    .A(a), .ad_in(adi), .ad_out(dout[0]), .ad_oe(oe[0]),
    .READY(ready[0]), .mem_req(req[0]), .mem_we(we[0]),
    .mem_addr(maddr0), .mem_wdata(wdat[0]), .mem_rdata(rdata[0]),
    .mem_ack(ack[0]), .bus_err(berr[0])
  );

  i8088_bus_slave #(.WAIT_STATES(3)) u1 (
    .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD(rd), .WR(wr),
    .A(a), .ad_in(adi), .ad_out(dout[1]), .ad_oe(oe[1]),
    .READY(ready[1]), .mem_req(req[1]), .mem_we(we[1]),
    .mem_addr(maddr1), .mem_wdata(wdat[1]), .mem_rdata(rdata[1]),
    .mem_ack(ack[1]), .bus_err(berr[1])
  );

  i8088_bus_slave #(
    .IO_SPACE(1), .BASE_ADDR(20'h00300), .SIZE_LOG2(4)
  ) u2 (
    .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD(rd), .WR(wr),
    .A(a), .ad_in(adi), .ad_out(dout[2]), .ad_oe(oe[2]),
    .READY(ready[2]), .mem_req(req[2]), .mem_we(we[2]),
    .mem_addr(maddr2), .mem_wdata(wdat[2]), .mem_rdata(rdata[2]),
    .mem_ack(ack[2]), .bus_err(berr[2])
  );

  // Local memory model: ack pulses dly[i] cycles after the req cycle.
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      ack[i] = 1'b0;
      if (acnt[i] > 0) begin
        acnt[i]--;
        if (acnt[i] == 0) ack[i] = 1'b1;
      end
      if (req[i] === 1'b1) acnt[i] = dly[i];
    end
  end

  // One full bus cycle: T1 with ALE, strobe held for 8 cycles, release.
  // mode 0 = read, 1 = write, 2 = RD and WR low together.
  task automatic bus_cycle(input logic io, input logic [19:0] ad,
                           input int mode, input logic [7:0] wd);
    @(posedge clk); #1;
    ale = 1'b1; iom = io; a = ad[19:8]; adi = ad[7:0];
    rd = 1'b1; wr = 1'b1;
    @(posedge clk); #1;
    ale = 1'b0;
    if (mode == 0) rd = 1'b0;
    else if (mode == 1) begin wr = 1'b0; adi = wd; end
    else begin rd = 1'b0; wr = 1'b0; end
    for (int i = 0; i < 3; i++) begin
      nlow[i] = 0; nreq[i] = 0; firstlow[i] = -1;
      raddr[i] = 12'h000; rwe[i] = 1'b0; rwd[i] = 8'h00;
      oe_seen[i] = 1'b0; oedata[i] = 8'h00; oe_last[i] = 1'b0;
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (ready[i] !== 1'b1) begin
          nlow[i]++;
          if (firstlow[i] < 0) firstlow[i] = c;
        end
        if (req[i] === 1'b1) begin
          nreq[i]++;
          case (i)
            0: raddr[i] = maddr0;
            1: raddr[i] = maddr1;
            default: raddr[i] = {8'h00, maddr2};
          endcase
          rwe[i] = we[i];
          rwd[i] = wdat[i];
        end
        if (oe[i] === 1'b1 && !oe_seen[i]) begin
          oe_seen[i] = 1'b1;
          oedata[i] = dout[i];
        end
        oe_last[i] = oe[i];
      end
    end
    rd = 1'b1; wr = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) oe_after[i] = oe[i];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready[0] !== 1'b1) begin
      errors++; $display("FAIL rst_ready got=%b want=1", ready[0]);
    end
    checks++;
    if (oe[0] !== 1'b0) begin
      errors++; $display("FAIL rst_oe got=%b want=0", oe[0]);
    end
    checks++;
    if (req[0] !== 1'b0) begin
      errors++; $display("FAIL rst_req got=%b want=0", req[0]);
    end
    checks++;
    if (berr[0] !== 1'b0) begin
      errors++; $display("FAIL rst_berr got=%b want=0", berr[0]);
    end
    checks++;
    if ({dout[0], we[0], maddr0, wdat[0]} !== 29'h0) begin
      errors++;
      $display("FAIL rst_regs got=%h/%b/%h/%h want=0",
               dout[0], we[0], maddr0, wdat[0]);
    end
    rst = 1'b0;
  endtask

  task automatic test_mem_read;
    rdata[0] = 8'h5A;
    bus_cycle(1'b0, 20'hF0123, 0, 8'h00);
    checks++;
    if (nreq[0] !== 1 || raddr[0] !== 12'h123 || rwe[0] !== 1'b0) begin
      errors++;
      $display("FAIL rd_req got n=%0d a=%h we=%b want n=1 a=123 we=0",
               nreq[0], raddr[0], rwe[0]);
    end
    checks++;
    if (nlow[0] !== 2 || firstlow[0] !== 0) begin
      errors++;
      $display("FAIL rd_ready got low=%0d first=%0d want low=2 first=0",
               nlow[0], firstlow[0]);
    end
    checks++;
    if (oe_seen[0] !== 1'b1 || oedata[0] !== 8'h5A) begin
      errors++;
      $display("FAIL rd_data got oe=%b d=%h want oe=1 d=5a",
               oe_seen[0], oedata[0]);
    end
    checks++;
    if (oe_last[0] !== 1'b1 || oe_after[0] !== 1'b0) begin
      errors++;
      $display("FAIL rd_oe_span got last=%b after=%b want 1/0",
               oe_last[0], oe_after[0]);
    end
  endtask

  task automatic test_mem_write;
    bus_cycle(1'b0, 20'hF0FFF, 1, 8'hC3);
    checks++;
    if (nreq[1] !== 1 || rwe[1] !== 1'b1 || rwd[1] !== 8'hC3 ||
        raddr[1] !== 12'hFFF) begin
      errors++;
      $display("FAIL wr_req got n=%0d we=%b d=%h a=%h want 1/1/c3/fff",
               nreq[1], rwe[1], rwd[1], raddr[1]);
    end
    checks++;
    if (nlow[1] !== 3) begin
      errors++; $display("FAIL wr_ws3_low got=%0d want=3", nlow[1]);
    end
    checks++;
    if (nlow[0] !== 2 || oe_seen[1] !== 1'b0) begin
      errors++;
      $display("FAIL wr_ws1 got low=%0d oe=%b want low=2 oe=0",
               nlow[0], oe_seen[1]);
    end
  endtask

  task automatic test_unselected;
    bus_cycle(1'b0, 20'hE0123, 0, 8'h00);
    checks++;
    if (nreq[0] !== 0 || nlow[0] !== 0 || oe_seen[0] !== 1'b0) begin
      errors++;
      $display("FAIL unsel_mem got n=%0d low=%0d oe=%b want 0/0/0",
               nreq[0], nlow[0], oe_seen[0]);
    end
    bus_cycle(1'b1, 20'hF0123, 0, 8'h00);
    checks++;
    if (nreq[0] !== 0 || nlow[0] !== 0 || oe_seen[0] !== 1'b0) begin
      errors++;
      $display("FAIL unsel_iom got n=%0d low=%0d oe=%b want 0/0/0",
               nreq[0], nlow[0], oe_seen[0]);
    end
  endtask

  task automatic test_io;
    rdata[2] = 8'h77;
    bus_cycle(1'b1, 20'h0030F, 0, 8'h00);
    checks++;
    if (nreq[2] !== 1 || raddr[2] !== 12'h00F || nlow[2] !== 2) begin
      errors++;
      $display("FAIL io_rd got n=%0d a=%h low=%0d want 1/00f/2",
               nreq[2], raddr[2], nlow[2]);
    end
    checks++;
    if (oedata[2] !== 8'h77 || nreq[0] !== 0) begin
      errors++;
      $display("FAIL io_data got d=%h memreq=%0d want 77/0",
               oedata[2], nreq[0]);
    end
    bus_cycle(1'b1, 20'h00310, 0, 8'h00);
    checks++;
    if (nreq[2] !== 0 || nlow[2] !== 0) begin
      errors++;
      $display("FAIL io_out got n=%0d low=%0d want 0/0", nreq[2], nlow[2]);
    end
  endtask

  task automatic test_bus_err;
    bus_cycle(1'b0, 20'hF0010, 2, 8'h00);
    checks++;
    if (berr[0] !== 1'b1 || nreq[0] !== 0 || nlow[0] !== 0 ||
        oe_seen[0] !== 1'b0) begin
      errors++;
      $display("FAIL err_set got e=%b n=%0d low=%0d oe=%b want 1/0/0/0",
               berr[0], nreq[0], nlow[0], oe_seen[0]);
    end
    rdata[0] = 8'h11;
    bus_cycle(1'b0, 20'hF0011, 0, 8'h00);
    checks++;
    if (berr[0] !== 1'b1 || nreq[0] !== 1 || oedata[0] !== 8'h11) begin
      errors++;
      $display("FAIL err_sticky got e=%b n=%0d d=%h want 1/1/11",
               berr[0], nreq[0], oedata[0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (berr[0] !== 1'b0) begin
      errors++; $display("FAIL err_clear got=%b want=0", berr[0]);
    end
  endtask

  task automatic test_abort;
    int n, ridx, low, seen;
    logic [7:0] d;
    dly[0] = 5;
    rdata[0] = 8'hEE;
    @(posedge clk); #1;
    ale = 1'b1; iom = 1'b0; a = 12'hF02; adi = 8'h00;
    @(posedge clk); #1;
    ale = 1'b0; rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready[0] !== 1'b0) begin
      errors++; $display("FAIL abort_pre got=%b want=0", ready[0]);
    end
    ale = 1'b1; rd = 1'b1; adi = 8'h01;
    @(posedge clk); #1;
    checks++;
    if (ready[0] !== 1'b1 || oe[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got rdy=%b oe=%b want 1/0",
               ready[0], oe[0]);
    end
    ale = 1'b0; rd = 1'b0;
    n = 0; ridx = -1; low = 0; seen = 0; d = 8'h00;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (req[0] === 1'b1) begin
        n++;
        if (ridx < 0) ridx = c;
        rdata[0] = 8'h3C;
      end
      if (ready[0] !== 1'b1) low++;
      if (oe[0] === 1'b1 && seen == 0) begin seen = 1; d = dout[0]; end
    end
    rd = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (n !== 1 || ridx < 3) begin
      errors++;
      $display("FAIL abort_req got n=%0d idx=%0d want n=1 idx>=3",
               n, ridx);
    end
    checks++;
    if (seen !== 1 || d !== 8'h3C || low !== 6) begin
      errors++;
      $display("FAIL abort_data got oe=%0d d=%h low=%0d want 1/3c/6",
               seen, d, low);
    end
    dly[0] = 1;
  endtask

  task automatic test_reset_mid;
    int n, low;
    dly[0] = 5;
    @(posedge clk); #1;
    ale = 1'b1; iom = 1'b0; a = 12'hF03; adi = 8'h00;
    @(posedge clk); #1;
    ale = 1'b0; rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready[0] !== 1'b1 || oe[0] !== 1'b0 || req[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid got rdy=%b oe=%b req=%b want 1/0/0",
               ready[0], oe[0], req[0]);
    end
    rst = 1'b0; rd = 1'b1;
    n = 0; low = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (req[0] === 1'b1) n++;
      if (ready[0] !== 1'b1) low++;
    end
    checks++;
    if (n !== 0 || low !== 0) begin
      errors++;
      $display("FAIL rstmid_quiet got n=%0d low=%0d want 0/0", n, low);
    end
    dly[0] = 1;
    rdata[0] = 8'h99;
    bus_cycle(1'b0, 20'hF0300, 0, 8'h00);
    checks++;
    if (nreq[0] !== 1 || oedata[0] !== 8'h99 || nlow[0] !== 2) begin
      errors++;
      $display("FAIL rstmid_next got n=%0d d=%h low=%0d want 1/99/2",
               nreq[0], oedata[0], nlow[0]);
    end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_unselected();
    test_io();
    test_bus_err();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
